// File: rtl/gpr_pkg.sv
// gpr_pkg: shared defaults and helpers for the general-purpose register file.
//   GPR_DATA_W       default register width
//   GPR_NUM_REGS     default register count
//   GPR_DATA_RST_BIT reset value replicated across every data bit
//   gpr_addr_w()     address width for a given register count
package gpr_pkg;

  localparam int   GPR_DATA_W       = 16;
  localparam int   GPR_NUM_REGS     = 8;
  localparam logic GPR_DATA_RST_BIT = 1'b0;

  // Never narrower than one bit, even for the smallest legal file.
  function automatic int gpr_addr_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/gpr_file_if.sv
// gpr_file_if: control-unit <-> register-file bus.
//   master (decode/control): drives write, reserve and read requests,
//                            receives read data/valid, busy_vec, rsv_err.
//   slave  (gpr_file):       the reverse.
interface gpr_file_if
  import gpr_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = GPR_NUM_REGS
);
  localparam int ADDR_W = gpr_addr_w(NUM_REGS);

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                rsv_en;
  logic [ADDR_W-1:0]   rsv_addr;
  logic                rd_a_en;
  logic [ADDR_W-1:0]   rd_a_addr;
  logic [DATA_W-1:0]   rd_a_data;
  logic                rd_a_valid;
  logic                rd_b_en;
  logic [ADDR_W-1:0]   rd_b_addr;
  logic [DATA_W-1:0]   rd_b_data;
  logic                rd_b_valid;
  logic [NUM_REGS-1:0] busy_vec;
  logic                rsv_err;

  modport master (
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
           rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
    input  rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, busy_vec, rsv_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
           rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
    output rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, busy_vec, rsv_err
  );

endinterface

// File: rtl/gpr_read_port.sv
// gpr_read_port: one registered read port of the register file.
//   clk, rst            clock, async active-high reset
//   rd_en, rd_addr      read request
//   reg_q, busy_q       register contents and scoreboard before this edge
//   wr_hit, wr_addr,
//   wr_data             in-range write of this cycle (used for bypass)
//   rd_data, rd_valid   registered result, one cycle after the request
// Build option: GPR_BYPASS_EN forwards a same-cycle write to the read.
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = GPR_NUM_REGS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_en,
  input  logic [gpr_addr_w(NUM_REGS)-1:0]   rd_addr,
  input  logic [DATA_W-1:0]                 reg_q [NUM_REGS],
  input  logic [NUM_REGS-1:0]               busy_q,
  input  logic                              wr_hit,
  input  logic [gpr_addr_w(NUM_REGS)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_valid
);

`ifdef GPR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              in_range;
  logic              byp_hit;
  logic [DATA_W-1:0] data_d;
  logic              valid_d;

  always_comb begin
    data_d   = {DATA_W{GPR_DATA_RST_BIT}};
    valid_d  = 1'b0;
    in_range = 32'(rd_addr) < NUM_REGS;
    byp_hit  = BYPASS && wr_hit && (wr_addr == rd_addr);
    if (rd_en && in_range) begin
      // A forwarded write counts as current even if a reserve lands on the
      // same edge: that reserve only affects reads issued afterwards.
      if (byp_hit) begin
        data_d  = wr_data;
        valid_d = 1'b1;
      end else begin
        data_d  = reg_q[rd_addr];
        valid_d = !busy_q[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= {DATA_W{GPR_DATA_RST_BIT}};
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= data_d;
      rd_valid <= valid_d;
    end
  end

endmodule

// File: rtl/gpr_file.sv
// gpr_file: NUM_REGS x DATA_W register file with one write port, two
// registered read ports and a per-register busy scoreboard.
//   clk, rst  clock, async active-high reset
//   bus       gpr_file_if slave: write, reserve, read A/B, busy_vec, rsv_err
// Build option: GPR_BYPASS_EN (see gpr_read_port).
module gpr_file
  import gpr_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = GPR_NUM_REGS
) (
  input logic       clk,
  input logic       rst,
  gpr_file_if.slave bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                rsv_err_q;
  logic                rsv_err_d;
  logic                wr_hit;
  logic                rsv_hit;

  assign wr_hit  = bus.wr_en  && (32'(bus.wr_addr)  < NUM_REGS);
  assign rsv_hit = bus.rsv_en && (32'(bus.rsv_addr) < NUM_REGS);

  always_comb begin
    busy_d = busy_q;
    if (wr_hit)  busy_d[bus.wr_addr]  = 1'b0;
    // Applied after the write: a same-address reserve leaves a new producer
    // outstanding.
    if (rsv_hit) busy_d[bus.rsv_addr] = 1'b1;
    rsv_err_d = bus.rsv_en && (!rsv_hit || busy_q[bus.rsv_addr]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= {DATA_W{GPR_DATA_RST_BIT}};
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      if (wr_hit) regs_q[bus.wr_addr] <= bus.wr_data;
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  assign bus.busy_vec = busy_q;
  assign bus.rsv_err  = rsv_err_q;

  gpr_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rd_a (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (bus.rd_a_en),
    .rd_addr  (bus.rd_a_addr),
    .reg_q    (regs_q),
    .busy_q   (busy_q),
    .wr_hit   (wr_hit),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_data  (bus.rd_a_data),
    .rd_valid (bus.rd_a_valid)
  );

  gpr_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rd_b (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (bus.rd_b_en),
    .rd_addr  (bus.rd_b_addr),
    .reg_q    (regs_q),
    .busy_q   (busy_q),
    .wr_hit   (wr_hit),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .rd_data  (bus.rd_b_data),
    .rd_valid (bus.rd_b_valid)
  );

endmodule
